riscv_hpm_counter_bank: RTL and testbench
=========================================

Name: riscv_hpm_counter_bank

Overview:
Parametrised machine counter/performance-monitor CSR bank that generalises the single fixed mcycle counter into mcycle, minstret and NUM_HPM programmable mhpmcounterN/mhpmeventN pairs. Each counter accepts multi-count increments per cycle to suit dual-issue retirement. The bank provides mcountinhibit, mcounteren, sticky overflow flags and an overflow interrupt. It sits beside the CSR regfile and is selected by the CSR read/write decode.

Parameters:
NUM_HPM, 4, number of programmable counters (1..29), mapped to mhpmcounter3..3+NUM_HPM-1.
CNT_W, 64, counter width (33..64). Bits above CNT_W read as 0 and are discarded on write.
NUM_EVENTS, 16, event input count (1..31).
EVT_SEL_W, 5, stored width of each mhpmevent selector.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
freeze  in  1  debug halt; holds every counter
retire_cnt  in  2  instructions retired this cycle (0..2)
evt_inc  in  2*NUM_EVENTS  per-event 2-bit increment; event k is bits [2k+1:2k]
priv  in  2  current privilege (0=U, 1=S, 3=M)
ren  in  1  read enable
raddr  in  12  read CSR address
rdata  out  32  read data (combinational)
rd_illegal  out  1  read access not permitted (combinational)
wen  in  1  write enable
waddr  in  12  write CSR address
wdata  in  32  write data
wr_illegal  out  1  write to read-only or unpermitted address (combinational)
ovf_irq  out  1  overflow interrupt (registered)

Behaviour:
- Reset: all counters 0, mhpmevent 0, mcountinhibit 0, mcounteren 0, ovf 0, ovf_ie 0, ovf_irq 0. rdata, rd_illegal and wr_illegal are 0 whenever ren/wen is low.
- Bit layout for inhibit, counteren, ovf and ovf_ie: bit0 = CY, bit1 = reserved (reads 0), bit2 = IR, bit(3+i) = HPM i. Unimplemented bits are hardwired 0.
- Map: mcycle 0xB00/0xB80(hi), minstret 0xB02/0xB82, mhpmcounter(3+i) 0xB03+i/0xB83+i, mhpmevent(3+i) 0x323+i, mcountinhibit 0x320, mcounteren 0x306, ovf 0x7C0 (write-1-to-clear), ovf_ie 0x7C1.
- User shadows 0xC00+n / 0xC80+n: read-only copies.
- Increments per cycle, when freeze=0 and the inhibit bit is clear:
  - CY: +1.
  - IR: +retire_cnt.
  - HPM i: +evt_inc[sel-1], where sel=mhpmevent[i]. sel=0 or sel>NUM_EVENTS counts nothing.
- Arithmetic: sum is modulo 2^CNT_W. A carry out of bit CNT_W-1 sets ovf[n] sticky on the same clock edge.
- Counter write:
  - Low-half write replaces bits [31:0]; high-half write replaces [CNT_W-1:32]. The other half is untouched and there is no carry between halves.
  - A write in the same cycle as an increment wins; that cycle's increment is lost and no overflow is flagged.
- Event selector write stores wdata[EVT_SEL_W-1:0]. Other CSRs store wdata masked to implemented bits.
- ovf write: ovf <= ovf & ~wdata. If a new overflow and a clear hit the same bit in the same cycle, the set wins.
- ovf_irq is registered one cycle after (ovf & ovf_ie) becomes nonzero; it drops one cycle after that term clears.
- Read permission:
  - 0xB__/0x3__/0x7C_ addresses need priv=M.
  - 0xC__ addresses are legal for priv=M, or priv<M with mcounteren[n]=1.
  - Otherwise rd_illegal=1 and rdata=0. Unmapped addresses and unimplemented counters also give rd_illegal=1.
- Write permission: writes to 0xC__, unmapped addresses, or from priv<M assert wr_illegal and update no state.
- Reads return the pre-edge value: same-cycle read and write give the old data.
- Reset asserted mid-operation clears all state immediately (asynchronous). Counting resumes on the first edge after release.

Test Plan:
- Reset, release, freeze=0, idle 10 cycles -> mcycle reads 10 at 0xB00 (±1 for read alignment); minstret reads 0; ovf_irq=0.
- retire_cnt=2 for 5 cycles, then 1 for 3 cycles -> minstret=13. Set mcountinhibit=0x4, retire_cnt=2 for 4 cycles -> minstret still 13.
- mhpmevent3=2, evt_inc event1=3 for 4 cycles, event0=1 -> mhpmcounter3=12. Repeat with mhpmevent3=0 or 17 -> no change.
- Write 0xB83=0xFFFFFFFF and 0xB03=0xFFFFFFFE, ovf_ie=0x8, one event of 3 -> counter=1, ovf=0x8, ovf_irq=1 next cycle. Write 0x7C0=0x8 -> ovf=0, ovf_irq=0 the cycle after.
- Write 0xB00=0x100 while counting -> read 0x100 next cycle, then 0x101. Assert freeze for 5 cycles -> value unchanged.
- priv=U read 0xC00 with mcounteren=0 -> rd_illegal=1, rdata=0. Set mcounteren=0x1 -> returns mcycle. priv=U write 0xB00, or any write to 0xC00 -> wr_illegal=1, no change. Assert reset mid-count -> all reads 0.

Source files
------------

// File: rtl/riscv_hpm_counter_bank.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret and NUM_HPM
// programmable event counters with inhibit, counteren, sticky overflow and an overflow IRQ.
module riscv_hpm_counter_bank #(
   parameter int NUM_HPM    = 4,
   parameter int CNT_W      = 64,
   parameter int NUM_EVENTS = 16,
   parameter int EVT_SEL_W  = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    freeze,
   input  logic [1:0]              retire_cnt,
   input  logic [2*NUM_EVENTS-1:0] evt_inc,
   input  logic [1:0]              priv,
   input  logic                    ren,
   input  logic [11:0]             raddr,
   output logic [31:0]             rdata,
   output logic                    rd_illegal,
   input  logic                    wen,
   input  logic [11:0]             waddr,
   input  logic [31:0]             wdata,
   output logic                    wr_illegal,
   output logic                    ovf_irq
);

   localparam int NUM_CNT = 3 + NUM_HPM;

   function automatic logic [31:0] impl_mask_f();
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
      return m;
   endfunction

   localparam logic [31:0] IMPL = impl_mask_f();

   // Address blocks of 32 CSRs, keyed on addr[11:5]
   localparam logic [6:0] BLK_CNT_LO = 7'h58;  // 0xB00
   localparam logic [6:0] BLK_CNT_HI = 7'h5C;  // 0xB80
   localparam logic [6:0] BLK_EVT    = 7'h19;  // 0x320
   localparam logic [6:0] BLK_SH_LO  = 7'h60;  // 0xC00
   localparam logic [6:0] BLK_SH_HI  = 7'h64;  // 0xC80

   logic [CNT_W-1:0]     cnt_q   [NUM_CNT];
   logic [CNT_W-1:0]     cnt_d   [NUM_CNT];
   logic [CNT_W:0]       sum     [NUM_CNT];
   logic [1:0]           inc     [NUM_CNT];
   logic [EVT_SEL_W-1:0] evt_sel_q [NUM_HPM];
   logic [31:0]          inhibit_q, cen_q, ovf_q, ovf_ie_q;
   logic [31:0]          ovf_set, ovf_d;

   logic [4:0] wn, rn;
   logic       w_cnt_lo, w_cnt_hi, w_evt, w_inh, w_cen, w_ovf, w_ie, w_legal, w_go;
   logic       m_mode;

   assign wn     = waddr[4:0];
   assign rn     = raddr[4:0];
   assign m_mode = (priv == 2'b11);

   always_comb begin
      w_cnt_lo = (waddr[11:5] == BLK_CNT_LO) && IMPL[wn];
      w_cnt_hi = (waddr[11:5] == BLK_CNT_HI) && IMPL[wn];
      w_inh    = (waddr == 12'h320);
      w_evt    = (waddr[11:5] == BLK_EVT) && (wn >= 5'd3) && IMPL[wn];
      w_cen    = (waddr == 12'h306);
      w_ovf    = (waddr == 12'h7C0);
      w_ie     = (waddr == 12'h7C1);
      w_legal  = w_cnt_lo | w_cnt_hi | w_inh | w_evt | w_cen | w_ovf | w_ie;
      w_go     = wen && m_mode && w_legal;
   end

   assign wr_illegal = wen && !(m_mode && w_legal);

   // Per-counter increment sources; selector 0 or beyond NUM_EVENTS matches nothing
   always_comb begin
      inc[0] = 2'd1;
      inc[1] = 2'd0;
      inc[2] = retire_cnt;
      for (int i = 0; i < NUM_HPM; i++) begin
         inc[3+i] = 2'd0;
         for (int k = 0; k < NUM_EVENTS; k++)
            if (evt_sel_q[i] == EVT_SEL_W'(k + 1)) inc[3+i] = evt_inc[2*k +: 2];
      end
   end

   always_comb begin
      ovf_set = '0;
      for (int n = 0; n < NUM_CNT; n++) begin
         sum[n]   = {1'b0, cnt_q[n]} + {{(CNT_W-1){1'b0}}, inc[n]};
         cnt_d[n] = cnt_q[n];
         if (!freeze && !inhibit_q[n]) begin
            cnt_d[n]   = sum[n][CNT_W-1:0];
            ovf_set[n] = sum[n][CNT_W];
         end
         // A CSR write discards this cycle's increment and its carry
         if (w_go && w_cnt_lo && wn == 5'(n)) begin
            cnt_d[n]   = {cnt_q[n][CNT_W-1:32], wdata};
            ovf_set[n] = 1'b0;
         end
         if (w_go && w_cnt_hi && wn == 5'(n)) begin
            cnt_d[n]   = {wdata[CNT_W-33:0], cnt_q[n][31:0]};
            ovf_set[n] = 1'b0;
         end
      end
      cnt_d[1]   = '0;
      ovf_set[1] = 1'b0;
      ovf_d = ((ovf_q & ~((w_go && w_ovf) ? wdata : 32'h0)) | ovf_set) & IMPL;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int n = 0; n < NUM_CNT; n++) cnt_q[n] <= '0;
         for (int i = 0; i < NUM_HPM; i++) evt_sel_q[i] <= '0;
         inhibit_q <= '0;
         cen_q     <= '0;
         ovf_q     <= '0;
         ovf_ie_q  <= '0;
         ovf_irq   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < NUM_HPM; i++)
            if (w_go && w_evt && wn == 5'(3 + i)) evt_sel_q[i] <= wdata[EVT_SEL_W-1:0];
         if (w_go && w_inh) inhibit_q <= wdata & IMPL;
         if (w_go && w_cen) cen_q <= wdata & IMPL;
         if (w_go && w_ie)  ovf_ie_q <= wdata & IMPL;
         ovf_q   <= ovf_d;
         ovf_irq <= |(ovf_q & ovf_ie_q);
      end
   end

   logic [31:0] c_lo, c_hi, e_val, r_val;
   logic        r_legal;

   always_comb begin
      c_lo    = '0;
      c_hi    = '0;
      e_val   = '0;
      r_val   = '0;
      r_legal = 1'b0;
      for (int n = 0; n < NUM_CNT; n++)
         if (rn == 5'(n)) begin
            c_lo = cnt_q[n][31:0];
            c_hi = 32'(cnt_q[n] >> 32);
         end
      for (int i = 0; i < NUM_HPM; i++)
         if (rn == 5'(3 + i)) e_val = 32'(evt_sel_q[i]);

      if (raddr[11:5] == BLK_CNT_LO) begin
         r_legal = m_mode && IMPL[rn];
         r_val   = c_lo;
      end else if (raddr[11:5] == BLK_CNT_HI) begin
         r_legal = m_mode && IMPL[rn];
         r_val   = c_hi;
      end else if (raddr[11:5] == BLK_SH_LO) begin
         r_legal = IMPL[rn] && (m_mode || cen_q[rn]);
         r_val   = c_lo;
      end else if (raddr[11:5] == BLK_SH_HI) begin
         r_legal = IMPL[rn] && (m_mode || cen_q[rn]);
         r_val   = c_hi;
      end else if (raddr == 12'h320) begin
         r_legal = m_mode;
         r_val   = inhibit_q;
      end else if (raddr[11:5] == BLK_EVT) begin
         r_legal = m_mode && (rn >= 5'd3) && IMPL[rn];
         r_val   = e_val;
      end else if (raddr == 12'h306) begin
         r_legal = m_mode;
         r_val   = cen_q;
      end else if (raddr == 12'h7C0) begin
         r_legal = m_mode;
         r_val   = ovf_q;
      end else if (raddr == 12'h7C1) begin
         r_legal = m_mode;
         r_val   = ovf_ie_q;
      end

      rdata      = '0;
      rd_illegal = 1'b0;
      if (ren) begin
         rd_illegal = !r_legal;
         rdata      = r_legal ? r_val : 32'h0;
      end
   end

endmodule

// File: tb/tb_riscv_hpm_counter_bank.sv
// Directed bench for riscv_hpm_counter_bank: counting, inhibit, event select,
// overflow/IRQ, CSR write rules, privilege checks and asynchronous reset.
`timescale 1ns/1ps
module tb_riscv_hpm_counter_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic [1:0]  retire_cnt;
   logic [31:0] evt_inc;
   logic [1:0]  priv;
   logic        ren;
   logic [11:0] raddr;
   logic [31:0] rdata;
   logic        rd_illegal;
   logic        wen;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        wr_illegal;
   logic        ovf_irq;

   int n_tests = 0;
   int n_fail  = 0;

   always #50 clk = ~clk;

   riscv_hpm_counter_bank #(
      .NUM_HPM(4), .CNT_W(64), .NUM_EVENTS(16), .EVT_SEL_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .retire_cnt(retire_cnt),
      .evt_inc(evt_inc), .priv(priv), .ren(ren), .raddr(raddr), .rdata(rdata),
      .rd_illegal(rd_illegal), .wen(wen), .waddr(waddr), .wdata(wdata),
      .wr_illegal(wr_illegal), .ovf_irq(ovf_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Combinational read at the current time; no clock edge is consumed
   task automatic chk_rd(input string tag, input logic [11:0] a,
                         input logic [31:0] exp_d, input logic exp_ill);
      logic [31:0] d;
      logic        ill;
      ren   = 1'b1;
      raddr = a;
      #1;
      d   = rdata;
      ill = rd_illegal;
      ren = 1'b0;
      check({tag, "_data"}, d, exp_d);
      check({tag, "_ill"}, 32'(ill), 32'(exp_ill));
   endtask

   // Write spans exactly one rising edge and returns at the following negedge
   task automatic chk_wr(input string tag, input logic [11:0] a,
                         input logic [31:0] d, input logic exp_ill);
      logic ill;
      wen   = 1'b1;
      waddr = a;
      wdata = d;
      #1;
      ill = wr_illegal;
      @(negedge clk);
      wen = 1'b0;
      check({tag, "_wr_ill"}, 32'(ill), 32'(exp_ill));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; freeze = 1'b0; retire_cnt = 2'd0; evt_inc = '0; priv = 2'd3;
      ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
      cycles(3);
      chk_rd("rst_mcycle", 12'hB00, 32'h0, 1'b0);
      check("rst_irq", 32'(ovf_irq), 32'h0);

      rst_n = 1'b0;
      cycles(10);
      raddr = 12'hB00;
      #1;
      check("ren_low_rdata", rdata, 32'h0);
      check("ren_low_ill", 32'(rd_illegal), 32'h0);
      chk_rd("mcycle_10", 12'hB00, 32'd10, 1'b0);
      chk_rd("minstret_0", 12'hB02, 32'd0, 1'b0);
      chk_rd("ovf_rst", 12'h7C0, 32'h0, 1'b0);
      chk_rd("cen_rst", 12'h306, 32'h0, 1'b0);
      check("irq_idle", 32'(ovf_irq), 32'h0);

      // minstret with dual retirement, then inhibited
      retire_cnt = 2'd2; cycles(5);
      retire_cnt = 2'd1; cycles(3);
      retire_cnt = 2'd0;
      chk_rd("minstret_13", 12'hB02, 32'd13, 1'b0);
      chk_wr("inh_all", 12'h320, 32'hFFFF_FFFF, 1'b0);
      chk_rd("inh_mask", 12'h320, 32'h0000_007D, 1'b0);
      chk_wr("inh_ir", 12'h320, 32'h4, 1'b0);
      retire_cnt = 2'd2; cycles(4);
      retire_cnt = 2'd0;
      chk_rd("minstret_inh", 12'hB02, 32'd13, 1'b0);
      chk_wr("inh_clr", 12'h320, 32'h0, 1'b0);

      // Event selection: event0 = 1, event1 = 3 per cycle
      chk_wr("sel2", 12'h323, 32'd2, 1'b0);
      evt_inc = 32'hD; cycles(4); evt_inc = '0;
      chk_rd("hpm3_12", 12'hB03, 32'd12, 1'b0);
      chk_rd("hpm4_0", 12'hB04, 32'd0, 1'b0);
      chk_wr("sel0", 12'h323, 32'd0, 1'b0);
      evt_inc = 32'hD; cycles(4); evt_inc = '0;
      chk_rd("hpm3_sel0", 12'hB03, 32'd12, 1'b0);
      chk_wr("sel17", 12'h323, 32'd17, 1'b0);
      chk_rd("sel17_rb", 12'h323, 32'd17, 1'b0);
      evt_inc = 32'hD; cycles(4); evt_inc = '0;
      chk_rd("hpm3_sel17", 12'hB03, 32'd12, 1'b0);
      chk_wr("sel1", 12'h323, 32'd1, 1'b0);
      evt_inc = 32'hD; cycles(2); evt_inc = '0;
      chk_rd("hpm3_sel1", 12'hB03, 32'd14, 1'b0);
      chk_wr("sel_wide", 12'h323, 32'h3F, 1'b0);
      chk_rd("sel_trunc", 12'h323, 32'h1F, 1'b0);
      chk_rd("evt_unmapped", 12'h321, 32'h0, 1'b1);

      // Overflow, sticky flag and IRQ timing
      chk_wr("sel2b", 12'h323, 32'd2, 1'b0);
      chk_wr("hi_ff", 12'hB83, 32'hFFFF_FFFF, 1'b0);
      chk_wr("lo_fe", 12'hB03, 32'hFFFF_FFFE, 1'b0);
      chk_rd("hi_ff_rb", 12'hB83, 32'hFFFF_FFFF, 1'b0);
      chk_wr("ie8", 12'h7C1, 32'h8, 1'b0);
      evt_inc = 32'hC; cycles(1); evt_inc = '0;
      chk_rd("wrap_lo", 12'hB03, 32'd1, 1'b0);
      chk_rd("wrap_hi", 12'hB83, 32'd0, 1'b0);
      chk_rd("ovf_set", 12'h7C0, 32'h8, 1'b0);
      check("irq_not_yet", 32'(ovf_irq), 32'h0);
      cycles(1);
      check("irq_up", 32'(ovf_irq), 32'h1);
      chk_wr("ovf_w1c", 12'h7C0, 32'h8, 1'b0);
      chk_rd("ovf_clr", 12'h7C0, 32'h0, 1'b0);
      check("irq_lag", 32'(ovf_irq), 32'h1);
      cycles(1);
      check("irq_down", 32'(ovf_irq), 32'h0);

      // mcycle write while counting, freeze, same-cycle read/write
      chk_wr("mcy_100", 12'hB00, 32'h100, 1'b0);
      chk_rd("mcy_100_rb", 12'hB00, 32'h100, 1'b0);
      cycles(1);
      chk_rd("mcy_101", 12'hB00, 32'h101, 1'b0);
      freeze = 1'b1; cycles(5);
      chk_rd("mcy_frozen", 12'hB00, 32'h101, 1'b0);
      freeze = 1'b0;
      wen = 1'b1; waddr = 12'hB00; wdata = 32'h55;
      chk_rd("rd_old", 12'hB00, 32'h101, 1'b0);
      cycles(1);
      wen = 1'b0;
      chk_rd("mcy_55", 12'hB00, 32'h55, 1'b0);

      // Privilege and counteren
      priv = 2'd0;
      chk_rd("u_c00_deny", 12'hC00, 32'h0, 1'b1);
      chk_rd("u_b00_deny", 12'hB00, 32'h0, 1'b1);
      priv = 2'd3;
      chk_wr("cen1", 12'h306, 32'h1, 1'b0);
      priv = 2'd0;
      chk_rd("u_c00_ok", 12'hC00, 32'h56, 1'b0);
      chk_rd("u_c02_deny", 12'hC02, 32'h0, 1'b1);
      chk_wr("u_wr_b00", 12'hB00, 32'h0, 1'b1);
      chk_rd("u_c00_after", 12'hC00, 32'h57, 1'b0);
      priv = 2'd3;
      chk_wr("m_wr_c00", 12'hC00, 32'h0, 1'b1);
      chk_rd("mcy_58", 12'hB00, 32'h58, 1'b0);
      chk_rd("c01_unimpl", 12'hC01, 32'h0, 1'b1);
      chk_rd("b07_unimpl", 12'hB07, 32'h0, 1'b1);
      chk_rd("cen_kept", 12'h306, 32'h1, 1'b0);

      // Asynchronous reset mid-count
      retire_cnt = 2'd1; cycles(2);
      rst_n = 1'b1;
      #1;
      chk_rd("arst_mcycle", 12'hB00, 32'h0, 1'b0);
      chk_rd("arst_minstret", 12'hB02, 32'h0, 1'b0);
      chk_rd("arst_cen", 12'h306, 32'h0, 1'b0);
      chk_rd("arst_sel", 12'h323, 32'h0, 1'b0);
      check("arst_irq", 32'(ovf_irq), 32'h0);
      cycles(1);
      rst_n = 1'b0;
      cycles(3);
      chk_rd("resume_mcycle", 12'hB00, 32'd3, 1'b0);
      chk_rd("resume_minstret", 12'hB02, 32'd3, 1'b0);
      retire_cnt = 2'd0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
